keypad_encoder: RTL and testbench

Debounces and encodes the microwave's 10-key numeric keypad into a BCD digit plus a one-cycle valid strobe. It sits in the Control_Input path directly downstream of counter_mod8. That counter's divided output F is registered into a one-cycle `sample_en` strobe, which sets this block's debounce sampling rate. The outputs feed the digit shift/time-entry registers.

---
 rtl/keypad_encoder_if.sv | 21 ++
 rtl/keypad_encoder.sv | 139 +++++++++++++
 tb/tb_keypad_encoder.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_encoder_if.sv
// Keypad encoder signal bundle: divider strobe and raw key lines in, encoded digit and strobes out.
// valid/err are single-cycle strobes with no ready; the receiver must take them on the cycle they are high.
interface keypad_encoder_if;
  logic       sample_en;
  logic [9:0] keypad;
  logic [3:0] D;
  logic       valid;
  logic       err;
  logic       held;
  logic [1:0] dbg_state;

  modport master (
    output sample_en, keypad,
    input  D, valid, err, held, dbg_state
  );

  modport slave (
    input  sample_en, keypad,
    output D, valid, err, held, dbg_state
  );
endinterface

// File: rtl/keypad_encoder.sv
// Debounces the 10-key numeric keypad and encodes an accepted single key to BCD,
// flagging multi-key patterns and tracking the press until a clean release.
module keypad_encoder #(
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic            clock,
  input  logic            clearn,
  keypad_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] NSAMP = 4'(DEBOUNCE_SAMPLES);

  state_t     state_q;
  logic [9:0] sync1_q;
  logic [9:0] ks_q;
  logic [9:0] pat_q;
  logic [3:0] cnt_q;
  logic [3:0] d_q;
  logic       valid_q;
  logic       err_q;
  logic       held_q;

  logic       ks_nz;
  logic       ks_onehot;
  logic [3:0] ks_idx;
  logic [3:0] cnt_inc;

  // Accepting only ever happens while ks equals the candidate pattern, so encode ks directly.
  always_comb begin
    ks_nz     = |ks_q;
    ks_onehot = $onehot(ks_q);
    ks_idx    = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (ks_q[k]) ks_idx = 4'(k);
    end
    cnt_inc   = cnt_q + 4'd1;
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q <= S_IDLE;
      sync1_q <= '0;
      ks_q    <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= bus.keypad;
      ks_q    <= sync1_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bus.sample_en) begin
        unique case (state_q)
          S_IDLE: begin
            if (ks_nz) begin
              pat_q <= ks_q;
              if (NSAMP == 4'd1) begin
                if (ks_onehot) begin
                  d_q     <= ks_idx;
                  valid_q <= 1'b1;
                end else begin
                  err_q <= 1'b1;
                end
                state_q <= S_HELD;
                held_q  <= 1'b1;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= S_CONFIRM;
              end
            end
          end
          S_CONFIRM: begin
            if (!ks_nz) begin
              cnt_q   <= 4'd0;
              state_q <= S_IDLE;
            end else if (ks_q != pat_q) begin
              pat_q <= ks_q;
              cnt_q <= 4'd1;
            end else if (cnt_inc == NSAMP) begin
              if (ks_onehot) begin
                d_q     <= ks_idx;
                valid_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
              cnt_q   <= cnt_inc;
              state_q <= S_HELD;
              held_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_HELD: begin
            if (!ks_nz) begin
              if (NSAMP == 4'd1) begin
                cnt_q   <= 4'd0;
                state_q <= S_IDLE;
                held_q  <= 1'b0;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            // Any key seen while releasing restarts the zero count; no new press until a clean release.
            if (ks_nz) begin
              cnt_q <= 4'd0;
            end else if (cnt_inc == NSAMP) begin
              cnt_q   <= 4'd0;
              state_q <= S_IDLE;
              held_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.D         = d_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.held      = held_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: one unit with 3-sample debounce on an 8-clock strobe,
// one with single-sample debounce and the strobe tied high, both checked against a run-length model.
module tb_keypad_encoder;

  localparam int EW = 37;  // {cycle[31:0], err, D[3:0]}

  typedef struct {
    logic [9:0] run_pat;
    int         run_len;
    int         zero_run;
    bit         locked;
    logic [3:0] d;
  } mstate_t;

  logic clock;
  logic clearn;

  keypad_encoder_if ifa ();
  keypad_encoder_if ifb ();

  keypad_encoder #(.DEBOUNCE_SAMPLES(3)) u_dut_a (.clock(clock), .clearn(clearn), .bus(ifa));
  keypad_encoder #(.DEBOUNCE_SAMPLES(1)) u_dut_b (.clock(clock), .clearn(clearn), .bus(ifb));

  int errors = 0;
  int checks = 0;
  int mon_bad = 0;
  int unsigned cyc = 0;

  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];
  logic [EW-1:0] obs_q_a[$];
  logic [EW-1:0] obs_q_b[$];

  mstate_t ma, mb;
  logic [9:0] ha1, ha2, hb1, hb2;

  // ---------------- clock / strobe ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int se_div = 0;
  always @(negedge clock) begin
    se_div = (se_div == 7) ? 0 : se_div + 1;
    ifa.sample_en = (se_div == 0);
  end

  // ---------------- reference model ----------------
  // A press is a run of n identical nonzero samples; it is released by n consecutive zero samples.
  function automatic void model_step(inout mstate_t s, input logic [9:0] v, input int n,
                                     output bit ev, output bit ev_err);
    ev = 1'b0;
    ev_err = 1'b0;
    if (!s.locked) begin
      if (v == 10'd0) begin
        s.run_len = 0;
      end else begin
        if (s.run_len > 0 && v == s.run_pat) s.run_len++;
        else begin
          s.run_pat = v;
          s.run_len = 1;
        end
        if (s.run_len == n) begin
          ev = 1'b1;
          s.locked = 1'b1;
          s.zero_run = 0;
          if ($countones(v) == 1) begin
            for (int k = 0; k < 10; k++) if (v[k]) s.d = 4'(k);
          end else begin
            ev_err = 1'b1;
          end
        end
      end
    end else begin
      if (v == 10'd0) s.zero_run++;
      else s.zero_run = 0;
      if (s.zero_run == n) begin
        s.locked = 1'b0;
        s.run_len = 0;
      end
    end
  endfunction

  always @(posedge clock or negedge clearn) begin
    bit ev, ev_err;
    logic [9:0] cur_a, cur_b;
    if (!clearn) begin
      ha1 = '0; ha2 = '0; hb1 = '0; hb2 = '0;
      ma = '{default: 0};
      mb = '{default: 0};
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      cyc++;
      cur_a = ha2; ha2 = ha1; ha1 = ifa.keypad;
      cur_b = hb2; hb2 = hb1; hb1 = ifb.keypad;
      if (ifa.sample_en === 1'b1) begin
        model_step(ma, cur_a, 3, ev, ev_err);
        if (ev) exp_q_a.push_back({cyc, ev_err, ma.d});
      end
      if (ifb.sample_en === 1'b1) begin
        model_step(mb, cur_b, 1, ev, ev_err);
        if (ev) exp_q_b.push_back({cyc, ev_err, mb.d});
      end
    end
  end

  // ---------------- observation ----------------
  always @(negedge clock) begin
    if (ifa.valid === 1'b1 || ifa.err === 1'b1) obs_q_a.push_back({cyc, ifa.err, ifa.D});
    if (ifb.valid === 1'b1 || ifb.err === 1'b1) obs_q_b.push_back({cyc, ifb.err, ifb.D});
    if (ifa.held !== ma.locked || ifa.D !== ma.d) mon_bad++;
    if (ifb.held !== mb.locked || ifb.D !== mb.d) mon_bad++;
  end

  // ---------------- drivers ----------------
  task automatic wait_samples(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clock); while (ifa.sample_en !== 1'b1);
    end
    @(negedge clock);
    #1;
  endtask

  function automatic logic [9:0] pick_pat();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return 10'd0;
    if (r < 85) return 10'(1) << $urandom_range(0, 9);
    return 10'($urandom_range(1, 1023));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({ifa.valid, ifa.err, ifa.held, ifa.D} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got valid/err/held/D=%b expected 0000000", {ifa.valid, ifa.err, ifa.held, ifa.D});
    end
    @(negedge clock);
    clearn = 1'b1;
    wait_samples(1);
    ifa.keypad = 10'h010;
    wait_samples(4);
    checks++;
    if (ifa.held !== 1'b1 || ifa.D !== 4'd4) begin
      errors++;
      $display("FAIL reset_first_press: got held=%b D=%0d expected held=1 D=4", ifa.held, ifa.D);
    end
    @(posedge clock);
    #2;
    clearn = 1'b0;
    #1;
    obs_q_a.delete();
    obs_q_b.delete();
    checks++;
    if ({ifa.valid, ifa.err, ifa.held, ifa.D, ifb.held, ifb.D} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async: got held=%b D=%0d expected held=0 D=0", ifa.held, ifa.D);
    end
    @(negedge clock);
    clearn = 1'b1;
    wait_samples(4);
    checks++;
    if (obs_q_a.size() !== 1 || obs_q_a[0][4:0] !== 5'd4) begin
      errors++;
      $display("FAIL reset_repress: got events=%0d expected 1 with D=4", obs_q_a.size());
    end
    ifa.keypad = 10'h000;
    wait_samples(4);
    while (exp_q_a.size() != 0 || obs_q_a.size() != 0) begin
      logic [EW-1:0] got, want;
      got = (obs_q_a.size() != 0) ? obs_q_a.pop_front() : '1;
      want = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : '1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_events: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_clean_press();
    wait_samples(1);
    ifa.keypad = 10'h200;
    wait_samples(2);
    checks++;
    if (ifa.valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_early: got valid=%b expected 0", ifa.valid);
    end
    wait_samples(1);
    checks++;
    if (ifa.valid !== 1'b1 || ifa.D !== 4'd9 || ifa.held !== 1'b1) begin
      errors++;
      $display("FAIL clean_accept: got valid=%b D=%0d held=%b expected 1 9 1", ifa.valid, ifa.D, ifa.held);
    end
    @(negedge clock);
    checks++;
    if (ifa.valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_pulse_width: got valid=%b expected 0", ifa.valid);
    end
    ifa.keypad = 10'h000;
    wait_samples(2);
    checks++;
    if (ifa.held !== 1'b1) begin
      errors++;
      $display("FAIL clean_held_early: got held=%b expected 1", ifa.held);
    end
    wait_samples(1);
    checks++;
    if (ifa.held !== 1'b0) begin
      errors++;
      $display("FAIL clean_release: got held=%b expected 0", ifa.held);
    end
    for (int i = 0; i < 4; i++) begin
      int k;
      k = $urandom_range(0, 9);
      ifa.keypad = 10'(1) << k;
      wait_samples(3);
      checks++;
      if (ifa.valid !== 1'b1 || ifa.D !== 4'(k)) begin
        errors++;
        $display("FAIL clean_random_key: got valid=%b D=%0d expected 1 %0d", ifa.valid, ifa.D, k);
      end
      ifa.keypad = 10'h000;
      wait_samples(3 + $urandom_range(0, 2));
    end
    wait_samples(1);
    while (exp_q_a.size() != 0 || obs_q_a.size() != 0) begin
      logic [EW-1:0] got, want;
      got = (obs_q_a.size() != 0) ? obs_q_a.pop_front() : '1;
      want = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : '1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL clean_events: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_bounce();
    int base;
    base = obs_q_a.size();
    for (int i = 0; i < 6; i++) begin
      ifa.keypad = (i % 2 == 0) ? 10'h004 : 10'h000;
      wait_samples(1);
    end
    ifa.keypad = 10'h004;
    wait_samples(2);
    checks++;
    if (obs_q_a.size() !== base) begin
      errors++;
      $display("FAIL bounce_quiet: got events=%0d expected %0d", obs_q_a.size(), base);
    end
    wait_samples(1);
    checks++;
    if (ifa.valid !== 1'b1 || ifa.D !== 4'd2 || obs_q_a.size() !== base + 1) begin
      errors++;
      $display("FAIL bounce_accept: got valid=%b D=%0d expected 1 2", ifa.valid, ifa.D);
    end
    ifa.keypad = 10'h000;
    wait_samples(4);
    while (exp_q_a.size() != 0 || obs_q_a.size() != 0) begin
      logic [EW-1:0] got, want;
      got = (obs_q_a.size() != 0) ? obs_q_a.pop_front() : '1;
      want = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : '1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bounce_events: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_two_keys();
    ifa.keypad = 10'h00A;
    wait_samples(3);
    checks++;
    if (ifa.err !== 1'b1 || ifa.valid !== 1'b0 || ifa.D !== 4'd2 || ifa.held !== 1'b1) begin
      errors++;
      $display("FAIL two_keys: got err=%b valid=%b D=%0d held=%b expected 1 0 2 1",
               ifa.err, ifa.valid, ifa.D, ifa.held);
    end
    wait_samples(5);
    checks++;
    if (obs_q_a.size() !== 1) begin
      errors++;
      $display("FAIL two_keys_single: got events=%0d expected 1", obs_q_a.size());
    end
    ifa.keypad = 10'h000;
    wait_samples(4);
    for (int i = 0; i < 3; i++) begin
      logic [9:0] p;
      do p = 10'($urandom_range(1, 1023)); while ($countones(p) < 2);
      ifa.keypad = p;
      wait_samples(3);
      checks++;
      if (ifa.err !== 1'b1 || ifa.D !== 4'd2) begin
        errors++;
        $display("FAIL two_keys_random: got err=%b D=%0d expected 1 2 for %h", ifa.err, ifa.D, p);
      end
      ifa.keypad = 10'h000;
      wait_samples(4);
    end
    while (exp_q_a.size() != 0 || obs_q_a.size() != 0) begin
      logic [EW-1:0] got, want;
      got = (obs_q_a.size() != 0) ? obs_q_a.pop_front() : '1;
      want = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : '1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL two_keys_events: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_pattern_change();
    int k;
    ifa.keypad = 10'h001;
    wait_samples(2);
    ifa.keypad = 10'h002;
    wait_samples(2);
    checks++;
    if (obs_q_a.size() !== 0) begin
      errors++;
      $display("FAIL change_early: got events=%0d expected 0", obs_q_a.size());
    end
    wait_samples(1);
    checks++;
    if (ifa.valid !== 1'b1 || ifa.D !== 4'd1) begin
      errors++;
      $display("FAIL change_accept: got valid=%b D=%0d expected 1 1", ifa.valid, ifa.D);
    end
    ifa.keypad = 10'h000;
    wait_samples(4);
    k = $urandom_range(0, 9);
    ifa.keypad = 10'(1) << k;
    wait_samples(50);
    checks++;
    if (obs_q_a.size() !== 2 || ifa.D !== 4'(k)) begin
      errors++;
      $display("FAIL long_hold: got events=%0d D=%0d expected 2 %0d", obs_q_a.size(), ifa.D, k);
    end
    ifa.keypad = 10'h000;
    wait_samples(1);
    ifa.keypad = 10'(1) << k;
    wait_samples(1);
    ifa.keypad = 10'h000;
    wait_samples(2);
    ifa.keypad = 10'h040;
    wait_samples(5);
    checks++;
    if (obs_q_a.size() !== 2 || ifa.held !== 1'b1) begin
      errors++;
      $display("FAIL release_bounce: got events=%0d held=%b expected 2 1", obs_q_a.size(), ifa.held);
    end
    ifa.keypad = 10'h000;
    wait_samples(3);
    checks++;
    if (ifa.held !== 1'b0) begin
      errors++;
      $display("FAIL release_clean: got held=%b expected 0", ifa.held);
    end
    ifa.keypad = 10'h040;
    wait_samples(3);
    checks++;
    if (ifa.valid !== 1'b1 || ifa.D !== 4'd6) begin
      errors++;
      $display("FAIL release_new_press: got valid=%b D=%0d expected 1 6", ifa.valid, ifa.D);
    end
    ifa.keypad = 10'h000;
    wait_samples(4);
    while (exp_q_a.size() != 0 || obs_q_a.size() != 0) begin
      logic [EW-1:0] got, want;
      got = (obs_q_a.size() != 0) ? obs_q_a.pop_front() : '1;
      want = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : '1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL change_events: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_single_sample();
    int n;
    @(negedge clock);
    #1;
    ifb.keypad = 10'h080;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ifb.valid !== 1'b1 && n < 10);
    checks++;
    if (n !== 3 || ifb.D !== 4'd7) begin
      errors++;
      $display("FAIL ds1_latency: got clocks=%0d D=%0d expected 3 7", n, ifb.D);
    end
    @(negedge clock);
    checks++;
    if (ifb.valid !== 1'b0 || ifb.held !== 1'b1) begin
      errors++;
      $display("FAIL ds1_pulse: got valid=%b held=%b expected 0 1", ifb.valid, ifb.held);
    end
    #1;
    ifb.keypad = 10'h000;
    repeat (3) @(negedge clock);
    checks++;
    if (ifb.held !== 1'b0) begin
      errors++;
      $display("FAIL ds1_release: got held=%b expected 0", ifb.held);
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      ifb.keypad = 10'(1) << $urandom_range(0, 9);
      repeat ($urandom_range(1, 6)) @(negedge clock);
      #1;
      ifb.keypad = 10'h000;
      repeat ($urandom_range(1, 6)) @(negedge clock);
    end
    repeat (6) @(negedge clock);
    #1;
    while (exp_q_b.size() != 0 || obs_q_b.size() != 0) begin
      logic [EW-1:0] got, want;
      got = (obs_q_b.size() != 0) ? obs_q_b.pop_front() : '1;
      want = (exp_q_b.size() != 0) ? exp_q_b.pop_front() : '1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ds1_events: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2400; c++) begin
      @(negedge clock);
      #1;
      if ($urandom_range(0, 5) == 0) ifa.keypad = pick_pat();
      if ($urandom_range(0, 5) == 0) ifb.keypad = pick_pat();
    end
    ifa.keypad = 10'h000;
    ifb.keypad = 10'h000;
    wait_samples(5);
    while (exp_q_a.size() != 0 || obs_q_a.size() != 0) begin
      logic [EW-1:0] got, want;
      got = (obs_q_a.size() != 0) ? obs_q_a.pop_front() : '1;
      want = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : '1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_events_a: got %h expected %h", got, want);
      end
    end
    while (exp_q_b.size() != 0 || obs_q_b.size() != 0) begin
      logic [EW-1:0] got, want;
      got = (obs_q_b.size() != 0) ? obs_q_b.pop_front() : '1;
      want = (exp_q_b.size() != 0) ? exp_q_b.pop_front() : '1;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_events_b: got %h expected %h", got, want);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clearn = 1'b0;
    ifa.keypad = 10'h000;
    ifb.keypad = 10'h000;
    ifb.sample_en = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_pattern_change();
    test_single_sample();
    test_random();
    checks++;
    if (mon_bad !== 0) begin
      errors++;
      $display("FAIL held_d_tracking: got %0d mismatching cycles expected 0", mon_bad);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
